// File: rtl/cache_line_burst_if.sv
// Line-granular burst engine between the L1 controller and a word-wide memory bus.
// Writebacks post WORDS_PER_LINE writes; refills pipeline reads and assemble in-order responses.
module cache_line_burst_if #(
    parameter int WORDS_PER_LINE  = 4,
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int OFFSET_BITS     = $clog2(WORDS_PER_LINE * DATA_W / 8)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ctrl_req_valid,
    output logic                             ctrl_req_ready,
    input  logic                             ctrl_req_we,
    input  logic [ADDR_W-1:0]                ctrl_req_addr,
    input  logic [WORDS_PER_LINE*DATA_W-1:0] ctrl_req_wline,
    output logic [WORDS_PER_LINE*DATA_W-1:0] ctrl_rline,
    output logic                             ctrl_done,
    output logic                             ctrl_busy,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic                             mem_req_we,
    output logic [ADDR_W-1:0]                mem_req_addr,
    output logic [DATA_W-1:0]                mem_req_wdata,
    input  logic                             mem_resp_valid,
    input  logic [DATA_W-1:0]                mem_resp_rdata,
    output logic                             err_unexpected_resp
);

    localparam int IDX_W   = $clog2(WORDS_PER_LINE);
    localparam int CNT_W   = IDX_W + 1;
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST      = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0]  MAX_OUT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFFSET_BITS) - ADDR_W'(1));

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                              state_q, state_d;
    logic [ADDR_W-1:0]                       base_q, base_d;
    logic [WORDS_PER_LINE-1:0][DATA_W-1:0]   wline_q, wline_d;
    logic [WORDS_PER_LINE-1:0][DATA_W-1:0]   rline_q, rline_d;
    logic [CNT_W-1:0]                        issue_q, issue_d;
    logic [CNT_W-1:0]                        resp_q, resp_d;
    logic                                    err_q, err_d;
    logic [CNT_W-1:0]                        outstanding;
    logic                                    accept;
    logic                                    resp_ok;

    // All request outputs decode registered state, so reset withdraws them at once.
    assign outstanding   = issue_q - resp_q;
    assign mem_req_valid = (state_q == S_WRITE) ||
                           ((state_q == S_READ) && (issue_q < LAST) && (outstanding < MAX_OUT));
    assign mem_req_we    = (state_q == S_WRITE);
    assign mem_req_addr  = mem_req_valid ? base_q + (ADDR_W'(issue_q) << BYTE_SH) : '0;
    assign mem_req_wdata = mem_req_we ? wline_q[issue_q[IDX_W-1:0]] : '0;

    assign accept  = mem_req_valid && mem_req_ready;
    assign resp_ok = mem_resp_valid && (state_q == S_READ) && (outstanding != '0);

    assign ctrl_req_ready      = (state_q == S_IDLE);
    assign ctrl_busy           = (state_q != S_IDLE);
    assign ctrl_done           = (state_q == S_DONE);
    assign ctrl_rline          = rline_q;
    assign err_unexpected_resp = err_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        wline_d = wline_q;
        rline_d = rline_q;
        issue_d = issue_q;
        resp_d  = resp_q;
        // A response nobody asked for is flagged and otherwise dropped.
        err_d   = err_q | (mem_resp_valid & ~resp_ok);
        case (state_q)
            S_IDLE: begin
                if (ctrl_req_valid) begin
                    base_d  = ctrl_req_addr & BASE_MASK;
                    wline_d = ctrl_req_wline;
                    issue_d = '0;
                    resp_d  = '0;
                    state_d = ctrl_req_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    issue_d = issue_q + ONE;
                    if (issue_q == LAST - ONE) state_d = S_DONE;
                end
            end
            S_READ: begin
                if (accept) issue_d = issue_q + ONE;
                if (resp_ok) begin
                    rline_d[resp_q[IDX_W-1:0]] = mem_resp_rdata;
                    resp_d = resp_q + ONE;
                    if (resp_q == LAST - ONE) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            issue_q <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            issue_q <= issue_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/cache_line_burst_if.md
# cache_line_burst_if

Line-granular memory interface between the L1 cache controller and the word-wide memory bus. It turns one controller refill or writeback request into a burst of `WORDS_PER_LINE` word transactions. Read bursts are pipelined with a bounded number of outstanding requests, and in-order responses are assembled into a full line. It replaces the word-level passthrough path and adds valid/ready backpressure, burst sequencing and protocol-error detection.

## Interface
Parameters:
- `WORDS_PER_LINE`, 4: words per cache line; power of two, ≥2.
- `DATA_W`, 32: memory word width in bits; power of two, ≥8.
- `ADDR_W`, 32: byte address width.
- `MAX_OUTSTANDING`, 2: maximum read beats accepted but not yet responded to; range 1..`WORDS_PER_LINE`.
- `OFFSET_BITS`, derived as log2(`WORDS_PER_LINE`·`DATA_W`/8): line offset bits.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ctrl_req_valid` in 1: controller line request.
- `ctrl_req_ready` out 1: block can accept a request; high only in IDLE.
- `ctrl_req_we` in 1: 1 = writeback, 0 = refill.
- `ctrl_req_addr` in `ADDR_W`: any byte address inside the line; the low `OFFSET_BITS` are ignored.
- `ctrl_req_wline` in `WORDS_PER_LINE`·`DATA_W`: writeback line; word i is at bits [i·`DATA_W` +: `DATA_W`].
- `ctrl_rline` out `WORDS_PER_LINE`·`DATA_W`: refilled line, same packing.
- `ctrl_done` out 1: one-cycle pulse when the request completes.
- `ctrl_busy` out 1: high in any state other than IDLE.
- `mem_req_valid` out 1: word request valid.
- `mem_req_ready` in 1: memory accepts the request in this cycle.
- `mem_req_we` out 1: word write.
- `mem_req_addr` out `ADDR_W`: word byte address.
- `mem_req_wdata` out `DATA_W`: write word.
- `mem_resp_valid` in 1: read response valid. Responses return in request order and cannot be stalled.
- `mem_resp_rdata` in `DATA_W`: read response data.
- `err_unexpected_resp` out 1: sticky flag; set by a response that no request accounts for.

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - On `ctrl_req_valid && ctrl_req_ready`, capture the line base (address with the low `OFFSET_BITS` cleared), the write line and `ctrl_req_we`.
  - Clear `issue_cnt` and `resp_cnt`.
  - Go to WRITE if `ctrl_req_we`, otherwise READ.
- Beat addressing: beat i address = base + i·(`DATA_W`/8). Beats are issued in ascending order with no wrap; the burst is always line-aligned.
- WRITE:
  - Drive `mem_req_valid` = 1, `mem_req_we` = 1, with address and data for beat `issue_cnt`.
  - `issue_cnt` increments on each `mem_req_ready`.
  - Go to DONE in the cycle after the last beat is accepted. Writes are posted; no response is expected.
- READ:
  - `outstanding` = `issue_cnt` − `resp_cnt`, computed from registered values.
  - `mem_req_valid` = (`issue_cnt` < `WORDS_PER_LINE`) && (`outstanding` < `MAX_OUTSTANDING`), with `mem_req_we` = 0.
  - Each `mem_resp_valid` writes word `resp_cnt` of `ctrl_rline` and increments `resp_cnt`.
  - An accept and a response in the same cycle are both honoured.
  - Go to DONE when `resp_cnt` reaches `WORDS_PER_LINE`.
- DONE: `ctrl_done` = 1 for exactly one cycle, then go to IDLE.
- `ctrl_rline` holds its value until the first response of the next refill. A writeback does not disturb it.
- Protocol error handling: a `mem_resp_valid` that arrives in IDLE, WRITE or DONE, or in READ with `outstanding` = 0, does the following:
  - sets `err_unexpected_resp`;
  - is otherwise ignored: no data is written and no counter changes.
- `err_unexpected_resp` clears only on reset.
- Counters are log2(`WORDS_PER_LINE`)+1 bits wide so the terminal count is representable.

## Timing
- Reset values:
  - state = IDLE, so `ctrl_req_ready` = 1;
  - `ctrl_busy`, `ctrl_done`, `mem_req_valid`, `mem_req_we`, `err_unexpected_resp` = 0;
  - `mem_req_addr`, `mem_req_wdata`, `ctrl_rline` = 0.
- Reset mid-burst aborts the burst immediately:
  - `mem_req_valid` drops asynchronously;
  - no `ctrl_done` is generated;
  - the system resets memory together with this block.
- Request accepted in cycle 0 → first `mem_req_valid` in cycle 1.
- While `mem_req_valid` is high and `mem_req_ready` is low, address, data and we are held stable, and valid is not withdrawn.
- Zero-wait memory (ready always 1, response one cycle after accept):
  - Write: beats in cycles 1..W, `ctrl_done` in cycle W+1.
  - Read with `MAX_OUTSTANDING` ≥ 2: beats in cycles 1..W, responses in cycles 2..W+1, `ctrl_done` in cycle W+2.
  - Read with `MAX_OUTSTANDING` = 1: beats every other cycle.
- `ctrl_req_ready` returns to 1 in the cycle after `ctrl_done`. Minimum spacing between two accepted requests is W+2 cycles for writes and W+3 cycles for reads.
- `ctrl_req_valid` while busy is ignored, not queued.

## Test plan
- Refill, W=4, zero-wait memory, addr 0x1008, memory words 0xA0..0xA3 at 0x1000..0x100C:
  - addresses 0x1000, 0x1004, 0x1008, 0x100C;
  - `ctrl_rline` = {A3,A2,A1,A0};
  - `ctrl_done` in cycle 6.
- Writeback, addr 0x2000, line {D3,D2,D1,D0}, `mem_req_ready` low for 3 cycles on beat 1:
  - beat 1 address and data are held stable during the stall;
  - four writes are seen in order;
  - `ctrl_done` in cycle 8;
  - no error.
- Refill, `MAX_OUTSTANDING` = 2, responses delayed 4 cycles:
  - `mem_req_valid` never high while two beats are outstanding;
  - the line is correct.
- `mem_resp_valid` pulsed while idle, then a normal refill:
  - `err_unexpected_resp` = 1 and stays 1;
  - `ctrl_rline` is unaffected by the stray response.
- `rst_n` asserted after 2 of 4 read beats:
  - all outputs return to reset values immediately;
  - no `ctrl_done`;
  - the next refill completes normally.
- Back-to-back writeback then refill with `ctrl_req_valid` held high:
  - second request accepted the cycle after the first `ctrl_done`;
  - `ctrl_rline` is unchanged by the writeback.
